// File: rtl/matmul_c_drain.sv
// rtl/matmul_c_drain.sv - drains result BRAM C onto a valid/ready stream after matmul completes
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   mm_done     completion pulse from matmul_top, sampled only while idle
//   c_rd_addr   registered read address to the C BRAM synchronous read port
//   c_rd_dout   C BRAM read data, valid one cycle after the BRAM registers the address
//   out_data    stream data (FIFO head)
//   out_valid   stream valid (FIFO not empty)
//   out_ready   stream ready from consumer
//   out_last    high with the final word of the matrix
//   busy        high from drain start until drain_done
//   drain_done  one-cycle pulse after the last word is accepted

module matmul_c_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MATRIX_SIZE = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mm_done,
    output logic [ADDR_WIDTH-1:0] c_rd_addr,
    input  logic [DATA_WIDTH-1:0] c_rd_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drain_done
);

    localparam int NUM_WORDS = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IDX_W     = $clog2(NUM_WORDS) + 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

    generate
        if (NUM_WORDS > (1 << ADDR_WIDTH)) begin : g_addr_check
            $fatal(1, "matmul_c_drain: MATRIX_SIZE^2 exceeds the C BRAM address space");
        end
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
            $fatal(1, "matmul_c_drain: FIFO_DEPTH must be a power of two and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Two-stage read pipe: stage 1 = address held in our register, stage 2 =
    // BRAM output register holds the word. Each stage carries its last tag.
    logic s1_q, s2_q, l1_q, l2_q;

    logic [DATA_WIDTH-1:0] mem_q      [FIFO_DEPTH];
    logic                  mem_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic           push, pop, issue, in_read;
    logic [CNT_W:0] used;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mm_done) state_d = S_READ;
            S_READ:  if (issue && rd_idx_q == LAST_IDX) state_d = S_DRAIN;
            // Looks at post-edge occupancy so drain_done follows the final
            // transfer by exactly one cycle. A word in stage 2 is already
            // counted in count_d; stage 1 moves to stage 2 this edge.
            S_DRAIN: if (count_d == '0 && !s1_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        drain_done = 1'b0;
        in_read    = 1'b0;
        case (state_q)
            S_READ: begin
                busy    = 1'b1;
                in_read = 1'b1;
            end
            S_DRAIN: busy       = 1'b1;
            S_DONE:  drain_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Read issue with FIFO credit ----------------
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = s2_q;

    // Slots committed after this edge if nothing new were issued; a pop at
    // this edge frees its slot immediately.
    assign used = {1'b0, count_q} + (CNT_W + 1)'(s1_q) + (CNT_W + 1)'(s2_q)
                  - (CNT_W + 1)'(pop);

    assign issue = in_read && (rd_idx_q <= LAST_IDX) && (used < DEPTH_C);

    always_comb begin
        rd_idx_d = rd_idx_q;
        addr_d   = addr_q;
        if (state_q == S_IDLE) begin
            rd_idx_d = '0;
        end else if (issue) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            addr_d   = ADDR_WIDTH'(rd_idx_q);
        end
    end

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_idx_q <= '0;
            addr_q   <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            l1_q     <= 1'b0;
            l2_q     <= 1'b0;
        end else begin
            rd_idx_q <= rd_idx_d;
            addr_q   <= addr_d;
            s1_q     <= issue;
            l1_q     <= issue && (rd_idx_q == LAST_IDX);
            s2_q     <= s1_q;
            l2_q     <= l1_q;
        end
    end

    // ---------------- Output FIFO ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i]      <= '0;
                mem_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]      <= c_rd_dout;
                mem_last_q[wr_ptr_q] <= l2_q;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign c_rd_addr = addr_q;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid && mem_last_q[rd_ptr_q];

endmodule

// File: tb/tb_matmul_c_drain.sv
// tb/tb_matmul_c_drain.sv - self-checking bench for matmul_c_drain

module tb_matmul_c_drain;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MS = 8;
    localparam int FD = 4;
    localparam int NW = MS * MS;

    logic          clock;
    logic          reset;
    logic          mm_done;
    logic [AW-1:0] c_rd_addr;
    logic [DW-1:0] c_rd_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          drain_done;

    matmul_c_drain #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MATRIX_SIZE(MS),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mm_done   (mm_done),
        .c_rd_addr (c_rd_addr),
        .c_rd_dout (c_rd_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .drain_done(drain_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read BRAM model for C
    logic [DW-1:0] cmem [1024];
    always @(posedge clock) c_rd_dout <= cmem[c_rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int k, input bit inv);
        logic [DW-1:0] v;
        v = DW'(k);
        return inv ? ~v : (32'h1000 + v);
    endfunction

    task automatic load_c(input bit inv);
        for (int i = 0; i < NW; i++) cmem[i] = exp_word(i, inv);
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check("idle_valid", out_valid, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_drain_done", drain_done, 1'b0);
        end
    endtask

    // mode 0: ready high, 1: fixed 50% ready pattern, 2: 20-cycle stall after
    // first word, 3: mm_done re-pulsed at word 30, 4: reset at word 40
    task automatic run_drain(input int mode, input bit inv);
        int n, c, stall_left, first_c, dones, last_c;
        bit prev_hold, exp_done_next, repulsed;
        logic [DW-1:0] prev_data;
        logic prev_lastf;
        logic [15:0] pat;
        pat = 16'hB4D2;
        n = 0; c = 0; stall_left = 0; first_c = -1; dones = 0; last_c = -1;
        prev_hold = 0; exp_done_next = 0; repulsed = 0;
        prev_data = '0; prev_lastf = 1'b0;

        mm_done   = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        mm_done = 1'b0;

        while (c < 3000) begin
            if (mode == 4 && n == 40) begin
                reset = 1'b0;
                #1;
                check("rst_valid", out_valid, 1'b0);
                check("rst_last", out_last, 1'b0);
                check("rst_data", out_data, 32'h0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", drain_done, 1'b0);
                check("rst_addr", c_rd_addr, 10'd0);
                @(negedge clock);
                reset = 1'b1;
                return;
            end

            check("drain_done_timing", drain_done, exp_done_next);
            check("busy", busy, !drain_done);
            if (drain_done) dones++;
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_lastf);
            end
            if (out_valid && first_c < 0) begin
                first_c = c;
                check("first_valid_latency", c, 3);
            end
            if (c >= 1 && busy)
                check("occupancy_bound", (int'(c_rd_addr) + 1 - n) <= FD, 1'b1);

            if (drain_done) begin
                @(negedge clock);
                check("done_pulse_width", drain_done, 1'b0);
                check("busy_after_done", busy, 1'b0);
                break;
            end

            mm_done = 1'b0;
            case (mode)
                1: out_ready = pat[c % 16];
                2: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        if (stall_left == 0) check("stall_addr_hold", c_rd_addr, 10'd4);
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                3: begin
                    out_ready = 1'b1;
                    if (n == 30 && !repulsed) begin
                        mm_done  = 1'b1;
                        repulsed = 1;
                    end
                end
                default: out_ready = 1'b1;
            endcase

            exp_done_next = 0;
            prev_hold = 0;
            if (out_valid && out_ready) begin
                if (n >= NW) begin
                    check("extra_word", n, NW - 1);
                end else begin
                    check("word_data", out_data, exp_word(n, inv));
                    check("word_last", out_last, n == NW - 1);
                    exp_done_next = (n == NW - 1);
                    if (n == NW - 1) last_c = c;
                end
                n++;
                if (mode == 2 && n == 1) stall_left = 20;
            end else if (out_valid) begin
                prev_hold  = 1;
                prev_data  = out_data;
                prev_lastf = out_last;
            end

            @(negedge clock);
            c++;
        end
        mm_done = 1'b0;
        check("drain_timeout", c < 3000, 1'b1);
        check("word_count", n, NW);
        check("done_count", dones, 1);
        if (mode == 0) check("last_word_cycle", last_c, 66);
    endtask

    typedef struct packed {
        logic          md;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          eb;
        logic          edn;
        logic [AW-1:0] ea;
    } vec_t;

    vec_t tv [12];

    initial begin
        tv[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 10'd0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 10'd0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 10'd0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 10'd1};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 10'd2};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 32'h1001, 1'b0, 1'b1, 1'b0, 10'd3};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 32'h1001, 1'b0, 1'b1, 1'b0, 10'd4};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 32'h1001, 1'b0, 1'b1, 1'b0, 10'd4};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 32'h1001, 1'b0, 1'b1, 1'b0, 10'd4};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 32'h1001, 1'b0, 1'b1, 1'b0, 10'd4};
        tv[10] = '{1'b0, 1'b1, 1'b1, 32'h1002, 1'b0, 1'b1, 1'b0, 10'd5};
        tv[11] = '{1'b0, 1'b1, 1'b1, 32'h1003, 1'b0, 1'b1, 1'b0, 10'd6};

        for (int i = 0; i < 1024; i++) cmem[i] = '0;
        load_c(0);
        reset     = 1'b0;
        mm_done   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);

        check("reset_valid", out_valid, 1'b0);
        check("reset_last", out_last, 1'b0);
        check("reset_data", out_data, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", drain_done, 1'b0);
        check("reset_addr", c_rd_addr, 10'd0);
        reset = 1'b1;

        for (int k = 0; k < 12; k++) begin
            mm_done   = tv[k].md;
            out_ready = tv[k].rdy;
            @(negedge clock);
            check($sformatf("vec%0d_valid", k), out_valid, tv[k].ev);
            check($sformatf("vec%0d_busy", k), busy, tv[k].eb);
            check($sformatf("vec%0d_done", k), drain_done, tv[k].edn);
            check($sformatf("vec%0d_addr", k), c_rd_addr, tv[k].ea);
            check($sformatf("vec%0d_last", k), out_last, tv[k].el);
            if (tv[k].ev) check($sformatf("vec%0d_data", k), out_data, tv[k].ed);
        end
        mm_done = 1'b0;

        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        idle_check(2);

        run_drain(0, 0);
        idle_check(3);
        run_drain(1, 0);
        idle_check(3);
        run_drain(2, 0);
        idle_check(3);
        run_drain(3, 0);
        idle_check(10);
        run_drain(4, 0);
        idle_check(5);
        check("post_reset_addr", c_rd_addr, 10'd0);
        run_drain(0, 0);

        run_drain(0, 0);
        load_c(1);
        run_drain(0, 1);
        idle_check(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
